axi_lite_gpio_poller: RTL and testbench
=======================================

AXI_LITE_GPIO_POLLER -- requirements
Module: axi_lite_gpio_poller

Interface
REQ-001 Parameter BASE_ADDR, 32'h0000_0000, byte base address of the target GPIO register block.
REQ-002 Parameter POLL_CYCLES, 1000, idle cycles between poll iterations (minimum 1).
REQ-003 Parameter DIR_VALUE, 32'h0000_00FF, value written to the direction register at start-up.
REQ-004 sys_clk  in  1  single clock; all logic rising-edge.
REQ-005 sys_resetn  in  1  asynchronous, active-low reset.
REQ-006 m_axi_awaddr  out  32  write address.
REQ-007 m_axi_awvalid  out  1  write address valid.
REQ-008 m_axi_awready  in  1  write address ready.
REQ-009 m_axi_wdata  out  32  write data.
REQ-010 m_axi_wstrb  out  4  write strobes, constant 4'hF.
REQ-011 m_axi_wvalid  out  1  write data valid.
REQ-012 m_axi_wready  in  1  write data ready.
REQ-013 m_axi_bresp  in  2  write response code.
REQ-014 m_axi_bvalid  in  1  write response valid.
REQ-015 m_axi_bready  out  1  write response ready.
REQ-016 m_axi_araddr  out  32  read address.
REQ-017 m_axi_arvalid  out  1  read address valid.
REQ-018 m_axi_arready  in  1  read address ready.
REQ-019 m_axi_rdata  in  32  read data.
REQ-020 m_axi_rresp  in  2  read response code.
REQ-021 m_axi_rvalid  in  1  read data valid.
REQ-022 m_axi_rready  out  1  read data ready.
REQ-023 dbg_data  out  32  last read DATA_IN word.
REQ-024 dbg_valid  out  1  one-cycle pulse when dbg_data updates.
REQ-025 err  out  1  sticky flag, set on any SLVERR/DECERR response.

Function
REQ-026 Register offsets SHALL be: DATA_OUT +0x00, DIR +0x04, DATA_IN +0x08.
REQ-027 States SHALL be: CFG_WR, CFG_B, WAIT, RD_A, RD_R, WR_A, WR_B; reset enters CFG_WR.
REQ-028 CFG_WR: assert awvalid and wvalid together (DIR address, DIR_VALUE); each drops independently after its ready handshake; both done -> CFG_B.
REQ-029 CFG_B/WR_B: bready=1; bvalid handshake -> WAIT, counter loaded with POLL_CYCLES-1.
REQ-030 WAIT: counter decrements each cycle; at 0 -> RD_A.
REQ-031 RD_A: arvalid=1 with DATA_IN address until arready -> RD_R; RD_R: rready=1 until rvalid.
REQ-032 On rvalid&rready: dbg_data<=rdata, dbg_valid=1 next cycle for exactly one cycle, pattern computed from rdata[3:0].
REQ-033 Pattern map: 0001->01, 0010->03, 0100->0F, 1000->FF, 0011->AA, 1100->F0, 0000->00; any other b -> {b,b}.
REQ-034 Write DATA_OUT with {24'b0,pattern} (WR_A, same rules as CFG_WR) only if pattern differs from last written value or no DATA_OUT write has occurred since reset; otherwise return to WAIT.
REQ-035 Valid signals SHALL never be withdrawn before handshake; addr/data SHALL be stable while valid.
REQ-036 awready/wready in any order or same cycle SHALL be accepted; no new request before prior response.
REQ-037 Non-OKAY bresp/rresp SHALL set err and continue normally; read data still used.

Reset
REQ-038 On sys_resetn low, immediately: all valid/ready outputs 0, addresses/wdata 0, dbg_data 0, dbg_valid 0, err 0, last-written cleared, state CFG_WR; mid-transaction reset abandons the transaction.

Structure
REQ-039 Register offsets, response codes and state encoding SHALL live in shared package axi_lite_gpio_pkg.
REQ-040 Write-channel handshake tracking SHALL be sub-module axi_lite_wr_channel; pattern map stays inline.

Verification
REQ-041 Reset release, slave always ready -> first write awaddr=0x04, wdata=0x000000FF, then first read at 0x08 after POLL_CYCLES.
REQ-042 rdata=0x1, then 0x3 -> DATA_OUT writes 0x01 then 0xAA; dbg_valid single-cycle pulses with dbg_data 0x1, 0x3.
REQ-043 rdata=0x4 two polls running -> exactly one DATA_OUT write (0x0F).
REQ-044 wready 3 cycles after awready, then reversed order -> each write completes once; valids held until own handshake.
REQ-045 bresp=2'b10 on DIR write -> err=1, stays 1, polling continues.
REQ-046 Reset asserted while arvalid=1 -> outputs zero at once; after release sequence restarts with DIR write.

Source files
------------

// File: rtl/axi_lite_gpio_pkg.sv
// Shared definitions for the AXI-Lite GPIO poller.
// Register map, response codes and FSM encoding.
package axi_lite_gpio_pkg;

    localparam logic [31:0] OFS_DATA_OUT = 32'h0000_0000;
    localparam logic [31:0] OFS_DIR      = 32'h0000_0004;
    localparam logic [31:0] OFS_DATA_IN  = 32'h0000_0008;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        CFG_WR,
        CFG_B,
        WAIT,
        RD_A,
        RD_R,
        WR_A,
        WR_B
    } state_t;

    // SLVERR and DECERR both carry bit 1 set
    function automatic logic resp_err(input logic [1:0] r);
        return r[1];
    endfunction

endpackage

// File: rtl/axi_lite_gpio_poller_if.sv
// AXI4-Lite bus bundle between the poller (master)
// and the GPIO register block (slave).
interface axi_lite_gpio_poller_if;

    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arvalid, rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axi_lite_wr_channel.sv
// AW/W issue with independent handshake tracking.
// done fires in the cycle the last of the two handshakes lands.
module axi_lite_wr_channel (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    output logic        awvalid,
    output logic [31:0] awaddr,
    input  logic        awready,
    output logic        wvalid,
    output logic [31:0] wdata,
    input  logic        wready,
    output logic        done
);

    logic busy;

    assign done = busy
                  && (!awvalid || awready)
                  && (!wvalid || wready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            awaddr  <= '0;
            wdata   <= '0;
        end else if (!busy) begin
            if (start) begin
                busy    <= 1'b1;
                awvalid <= 1'b1;
                wvalid  <= 1'b1;
                awaddr  <= addr;
                wdata   <= data;
            end
        end else begin
            if (awready) awvalid <= 1'b0;
            if (wready)  wvalid  <= 1'b0;
            if (done)    busy    <= 1'b0;
        end
    end

endmodule

// File: rtl/axi_lite_gpio_poller.sv
// Configures a GPIO block, then polls DATA_IN and mirrors
// a pattern derived from it onto DATA_OUT when it changes.
module axi_lite_gpio_poller
    import axi_lite_gpio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          POLL_CYCLES = 1000,
    parameter logic [31:0] DIR_VALUE   = 32'h0000_00FF
) (
    input  logic                          sys_clk,
    input  logic                          sys_resetn,
    axi_lite_gpio_poller_if.master        m_axi,
    output logic [31:0]                   dbg_data,
    output logic                          dbg_valid,
    output logic                          err
);

    localparam logic [31:0] POLL_LOAD = 32'(POLL_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  last_q;
    logic        last_vld_q;
    logic [7:0]  pat_q;
    logic [7:0]  pat;
    logic        wr_start;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_done;
    logic        rd_fire;
    logic        b_fire;

    assign wr_start = (state_q == CFG_WR) || (state_q == WR_A);
    assign wr_addr  = (state_q == CFG_WR) ? BASE_ADDR + OFS_DIR
                                          : BASE_ADDR + OFS_DATA_OUT;
    assign wr_data  = (state_q == CFG_WR) ? DIR_VALUE
                                          : {24'b0, pat_q};

    axi_lite_wr_channel u_wr (
        .clk     (sys_clk),
        .rst_n   (sys_resetn),
        .start   (wr_start),
        .addr    (wr_addr),
        .data    (wr_data),
        .awvalid (m_axi.awvalid),
        .awaddr  (m_axi.awaddr),
        .awready (m_axi.awready),
        .wvalid  (m_axi.wvalid),
        .wdata   (m_axi.wdata),
        .wready  (m_axi.wready),
        .done    (wr_done)
    );

    assign m_axi.wstrb   = 4'hF;
    assign m_axi.bready  = (state_q == CFG_B) || (state_q == WR_B);
    assign m_axi.arvalid = (state_q == RD_A);
    assign m_axi.araddr  = m_axi.arvalid ? BASE_ADDR + OFS_DATA_IN : '0;
    assign m_axi.rready  = (state_q == RD_R);

    assign rd_fire = m_axi.rready && m_axi.rvalid;
    assign b_fire  = m_axi.bready && m_axi.bvalid;

    always_comb begin
        pat = {m_axi.rdata[3:0], m_axi.rdata[3:0]};
        case (m_axi.rdata[3:0])
            4'b0001: pat = 8'h01;
            4'b0010: pat = 8'h03;
            4'b0100: pat = 8'h0F;
            4'b1000: pat = 8'hFF;
            4'b0011: pat = 8'hAA;
            4'b1100: pat = 8'hF0;
            4'b0000: pat = 8'h00;
            default: pat = {m_axi.rdata[3:0], m_axi.rdata[3:0]};
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            CFG_WR: if (wr_done) state_d = CFG_B;
            WR_A:   if (wr_done) state_d = WR_B;
            CFG_B, WR_B: begin
                if (m_axi.bvalid) begin
                    state_d = WAIT;
                    cnt_d   = POLL_LOAD;
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = RD_A;
                else             cnt_d   = cnt_q - 32'd1;
            end
            RD_A: if (m_axi.arready) state_d = RD_R;
            RD_R: begin
                if (m_axi.rvalid) begin
                    // Skip the write when DATA_OUT already holds it
                    if (!last_vld_q || pat != last_q) begin
                        state_d = WR_A;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = POLL_LOAD;
                    end
                end
            end
            default: state_d = CFG_WR;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            state_q    <= CFG_WR;
            cnt_q      <= '0;
            last_q     <= '0;
            last_vld_q <= 1'b0;
            pat_q      <= '0;
            dbg_data   <= '0;
            dbg_valid  <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dbg_valid <= 1'b0;
            if (rd_fire) begin
                dbg_data  <= m_axi.rdata;
                dbg_valid <= 1'b1;
                pat_q     <= pat;
                if (resp_err(m_axi.rresp)) err <= 1'b1;
            end
            if (b_fire && resp_err(m_axi.bresp)) err <= 1'b1;
            if (state_q == WR_A && wr_done) begin
                last_q     <= pat_q;
                last_vld_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_gpio_poller.sv
// Randomised AXI-Lite slave plus reference model
// for the GPIO poller.
module tb_axi_lite_gpio_poller;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          POLL = 4;
    localparam logic [31:0] DIRV = 32'h0000_00FF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] dbg_data;
    logic        dbg_valid;
    logic        err;

    axi_lite_gpio_poller_if bus();

    axi_lite_gpio_poller #(
        .BASE_ADDR   (BASE),
        .POLL_CYCLES (POLL),
        .DIR_VALUE   (DIRV)
    ) dut (
        .sys_clk    (clk),
        .sys_resetn (rst_n),
        .m_axi      (bus),
        .dbg_data   (dbg_data),
        .dbg_valid  (dbg_valid),
        .err        (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Pattern rule as a lookup table; anything unlisted repeats the nibble
    function automatic logic [7:0] ref_pat(input logic [31:0] d);
        logic [3:0] keys [7];
        logic [7:0] vals [7];
        keys = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'h0};
        vals = '{8'h01, 8'h03, 8'h0F, 8'hFF, 8'hAA, 8'hF0, 8'h00};
        for (int i = 0; i < 7; i++)
            if (keys[i] == d[3:0]) return vals[i];
        return {d[3:0], d[3:0]};
    endfunction

    int          cyc = 0;
    int          mark = -1000;
    int          n_reads = 0;
    int          wr_idx = 0;
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
    bit          aw_got, w_got, wr_seen, wr_chk, b_clr;
    bit          ar_seen, ar_got, r_clr;
    bit          rnd = 1'b0;
    bit          err_b_once = 1'b0;
    bit          err_rand = 1'b0;
    bit          have_last, exp_err, exp_dbg_v;
    bit          prev_awv, prev_wv, prev_arv;
    logic [31:0] prev_awaddr, prev_wdata, prev_araddr;
    logic [31:0] cap_awaddr, cap_wdata, exp_dbg_d;
    logic [7:0]  last_pat;
    logic [31:0] exp_a_q [$];
    logic [31:0] exp_d_q [$];
    logic [31:0] dir_q [$];

    function automatic int pick(input int fixed);
        return rnd ? int'($urandom_range(0, 3)) : fixed;
    endfunction

    function automatic logic [31:0] next_rdata();
        logic [31:0] v;
        if (dir_q.size() != 0) return dir_q.pop_front();
        v = $urandom;
        if ($urandom_range(0, 1) == 1) v[3:0] = 4'($urandom_range(0, 4));
        return v;
    endfunction

    function automatic logic [1:0] next_resp();
        if (err_rand && $urandom_range(0, 3) == 0)
            return 2'($urandom_range(1, 3));
        return 2'b00;
    endfunction

    task automatic reinit();
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        bus.bresp   = 2'b00;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rdata   = '0;
        bus.rresp   = 2'b00;
        {aw_got, w_got, wr_seen, wr_chk, b_clr} = '0;
        {ar_seen, ar_got, r_clr} = '0;
        {have_last, exp_err, exp_dbg_v} = '0;
        {prev_awv, prev_wv, prev_arv} = '0;
        wr_idx = 0;
        mark   = -1000;
        exp_a_q.delete();
        exp_d_q.delete();
        exp_a_q.push_back(BASE + 32'h4);
        exp_d_q.push_back(DIRV);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_awvalid"}, 32'(bus.awvalid), 0);
        chk({tag, "_wvalid"},  32'(bus.wvalid),  0);
        chk({tag, "_arvalid"}, 32'(bus.arvalid), 0);
        chk({tag, "_bready"},  32'(bus.bready),  0);
        chk({tag, "_rready"},  32'(bus.rready),  0);
        chk({tag, "_awaddr"},  bus.awaddr, 0);
        chk({tag, "_wdata"},   bus.wdata,  0);
        chk({tag, "_araddr"},  bus.araddr, 0);
        chk({tag, "_dbg_data"}, dbg_data, 0);
        chk({tag, "_dbg_valid"}, 32'(dbg_valid), 0);
        chk({tag, "_err"}, 32'(err), 0);
    endtask

    // Runs once per falling edge: check what the last edge produced,
    // then decide what the slave presents for the next rising edge.
    task automatic slave_step();
        logic [7:0] p;
        cyc++;
        if (!rst_n) begin
            reinit();
            return;
        end
        chk("dbg_valid", 32'(dbg_valid), 32'(exp_dbg_v));
        if (exp_dbg_v) chk("dbg_data", dbg_data, exp_dbg_d);
        chk("err", 32'(err), 32'(exp_err));
        exp_dbg_v = 1'b0;
        if (prev_awv) begin
            chk("awvalid_hold", 32'(bus.awvalid), 1);
            chk("awaddr_stable", bus.awaddr, prev_awaddr);
        end
        if (prev_wv) begin
            chk("wvalid_hold", 32'(bus.wvalid), 1);
            chk("wdata_stable", bus.wdata, prev_wdata);
        end
        if (prev_arv) begin
            chk("arvalid_hold", 32'(bus.arvalid), 1);
            chk("araddr_stable", bus.araddr, prev_araddr);
        end
        if (b_clr) begin
            bus.bvalid = 1'b0;
            b_clr = 1'b0;
        end
        if (r_clr) begin
            bus.rvalid = 1'b0;
            r_clr = 1'b0;
        end

        if (aw_got && w_got && !bus.bvalid) begin
            if (b_dly == 0) begin
                bus.bvalid = 1'b1;
                bus.bresp  = err_b_once ? 2'b10 : next_resp();
                err_b_once = 1'b0;
            end else b_dly--;
        end
        if (bus.bvalid && bus.bready) begin
            b_clr = 1'b1;
            if (bus.bresp[1]) exp_err = 1'b1;
            mark = cyc;
            {aw_got, w_got, wr_seen, wr_chk} = '0;
            wr_idx++;
        end

        if (ar_got && !bus.rvalid) begin
            if (r_dly == 0) begin
                bus.rvalid = 1'b1;
                bus.rdata  = next_rdata();
                bus.rresp  = next_resp();
            end else r_dly--;
        end
        if (bus.rvalid && bus.rready) begin
            r_clr = 1'b1;
            ar_got = 1'b0;
            ar_seen = 1'b0;
            n_reads++;
            mark = cyc;
            exp_dbg_v = 1'b1;
            exp_dbg_d = bus.rdata;
            if (bus.rresp[1]) exp_err = 1'b1;
            p = ref_pat(bus.rdata);
            if (!have_last || p != last_pat) begin
                exp_a_q.push_back(BASE);
                exp_d_q.push_back({24'b0, p});
                last_pat  = p;
                have_last = 1'b1;
            end
        end

        if ((bus.awvalid || bus.wvalid) && !wr_seen) begin
            wr_seen = 1'b1;
            aw_dly = pick(wr_idx == 2 ? 3 : 0);
            w_dly  = pick(wr_idx == 1 ? 3 : 0);
            b_dly  = pick(0);
        end
        bus.awready = 1'b0;
        if (bus.awvalid && !aw_got) begin
            if (aw_dly == 0) begin
                bus.awready = 1'b1;
                aw_got = 1'b1;
                cap_awaddr = bus.awaddr;
            end else aw_dly--;
        end
        bus.wready = 1'b0;
        if (bus.wvalid && !w_got) begin
            if (w_dly == 0) begin
                bus.wready = 1'b1;
                w_got = 1'b1;
                cap_wdata = bus.wdata;
                chk("wstrb", 32'(bus.wstrb), 32'hF);
            end else w_dly--;
        end
        if (aw_got && w_got && !wr_chk) begin
            wr_chk = 1'b1;
            chk("write_expected", 32'(exp_a_q.size() != 0), 1);
            if (exp_a_q.size() != 0) begin
                chk("write_addr", cap_awaddr, exp_a_q.pop_front());
                chk("write_data", cap_wdata, exp_d_q.pop_front());
            end
        end

        bus.arready = 1'b0;
        if (bus.arvalid && !ar_seen) begin
            ar_seen = 1'b1;
            ar_dly = pick(0);
            r_dly  = pick(0);
            chk("poll_gap", 32'(cyc - mark), 32'(POLL + 1));
            chk("pending_writes", 32'(exp_a_q.size()), 0);
            chk("araddr", bus.araddr, BASE + 32'h8);
        end
        if (bus.arvalid && !ar_got) begin
            if (ar_dly == 0) begin
                bus.arready = 1'b1;
                ar_got = 1'b1;
            end else ar_dly--;
        end

        prev_awv = bus.awvalid && !bus.awready;
        prev_wv  = bus.wvalid && !bus.wready;
        prev_arv = bus.arvalid && !bus.arready;
        prev_awaddr = bus.awaddr;
        prev_wdata  = bus.wdata;
        prev_araddr = bus.araddr;
    endtask

    initial begin
        reinit();
        forever begin
            @(negedge clk);
            slave_step();
        end
    end

    task automatic wait_reads(input int n, input int budget);
        int tgt;
        int k;
        tgt = n_reads + n;
        k = 0;
        while (n_reads < tgt && k < budget) begin
            @(negedge clk);
            k++;
        end
        #1;
        chk("reads_done", 32'(n_reads >= tgt), 1);
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clk);
        #1 check_zero("reset");
        dir_q = '{32'h1, 32'h3, 32'h4, 32'h4};
        @(negedge clk);
        #2 rst_n = 1'b1;
        wait_reads(4, 400);

        rnd = 1'b1;
        wait_reads(20, 800);

        k = 0;
        while (!bus.arvalid && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("arvalid_seen", 32'(bus.arvalid), 1);
        #2 rst_n = 1'b0;
        #1 check_zero("midreset");
        err_b_once = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        wait_reads(3, 200);
        chk("err_sticky", 32'(err), 1);

        err_rand = 1'b1;
        wait_reads(15, 600);
        chk("err_final", 32'(err), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
